keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Parametrised ROWS×COLS matrix-keypad scanner and event encoder, successor to the fixed 4×4 keypad decoder. It drives active-low row strobes, synchronises and debounces the active-low column returns, and emits linear key codes for press events and typematic repeat events. Events are buffered in a small FIFO with a valid/ready handshake toward the consuming logic, such as a display controller or command parser.

## Interface
- ROWS, 4, number of row lines; legal range 2..8
- COLS, 4, number of column lines; legal range 2..8
- SCAN_CYCLES, 4, cycles each row is strobed before columns are sampled; must be ≥3
- DEBOUNCE_CYCLES, 100, consecutive stable cycles required for a press or a release; must be ≥1
- REPEAT_DELAY, 0, held cycles before the first repeat event; 0 disables repeat
- REPEAT_RATE, 1, cycles between later repeat events; must be ≥1
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two, ≥2
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-low reset
- col_matriz  in  COLS  asynchronous column returns, active low
- lin_matriz  out  ROWS  row strobes, one-hot active low
- tecla_value  out  KEY_W = $clog2(ROWS*COLS)  key code at the FIFO head
- tecla_repeat  out  1  1 when the head event is a repeat, 0 when it is an initial press
- tecla_valid  out  1  FIFO not empty
- tecla_ready  in  1  consumer accepts the head entry
- tecla_held  out  1  high while in HELD or REL_DEB
- overflow  out  1  sticky; set when an event is dropped on a full FIFO

## Operation
- col_matriz passes through a 2-flop synchroniser reset to all ones. The synchronised value is col_s, and all column tests below use col_s.
- Key code = row*COLS + col. Mapping codes to glyphs is done downstream.
- If several columns are low, the lowest-index low column is taken.
- FSM states: SCAN, DEBOUNCE, HELD, REL_DEB.
  - **SCAN:** drive row r low for SCAN_CYCLES cycles. On the last cycle, if col_s ≠ all ones, latch r and c and go to DEBOUNCE. Otherwise set r = (r+1) mod ROWS (wraps ROWS-1 → 0) and stay in SCAN.
  - **DEBOUNCE:** row r stays driven. Each cycle col_s[c] must be 0. If col_s[c] = 1, go to SCAN at row (r+1) mod ROWS with no event. After DEBOUNCE_CYCLES consecutive cycles, push {repeat=0, code} and go to HELD.
  - **HELD:** if col_s[c] = 1, go to REL_DEB. Otherwise, when REPEAT_DELAY ≠ 0:
    - the hold counter reaching REPEAT_DELAY pushes {repeat=1, code};
    - after that, a push occurs every REPEAT_RATE cycles.
  - **REL_DEB:** if col_s[c] = 0, return to HELD with no event; the repeat counter continues and is not reset. After DEBOUNCE_CYCLES consecutive high cycles, go to SCAN at row (r+1) mod ROWS.
- Other keys pressed during HELD or REL_DEB are ignored.
- FIFO push rules:
  - When not full, the event is written.
  - When full and no pop occurs in the same cycle, the event is dropped and overflow is set.
  - A push and a pop in the same cycle on a full FIFO is accepted.
- FIFO pop occurs when tecla_valid && tecla_ready. tecla_ready is ignored when the FIFO is empty.
- Counter widths are $clog2(max+1) of their parameter. Counters saturate and never wrap.

## Timing
- **Reset values:** lin_matriz = ~1 (row 0 low), tecla_value = 0, tecla_repeat = 0, tecla_valid = 0, tecla_held = 0, overflow = 0. FSM = SCAN, r = 0, FIFO empty, synchroniser all ones.
- **Reset mid-operation:** all state is discarded on the next edge, including FIFO contents and any debounce in progress.
- **Press latency:** let t be the SCAN sample cycle. The press is pushed at t + DEBOUNCE_CYCLES. tecla_valid rises and the head is visible at t + DEBOUNCE_CYCLES + 1.
- **Column settle:** the synchroniser delays the column response by 2 cycles, which is why SCAN_CYCLES ≥ 3.
- **Handshake:** tecla_value and tecla_repeat are stable while tecla_valid = 1 and no pop occurs. After a pop, the next entry appears in the following cycle.
- **Throughput:** one pop per cycle.

## Structure
- Package keypad_pkg holds:
  - typedef enum scan_state_t {SCAN, DEBOUNCE, HELD, REL_DEB};
  - typedef struct packed key_evt_t {repeat, code}. The code width is derived from the parameters, so the struct is parametrised through a localparam in the top module; the package holds only the state enum and a default-width event for 4×4.
- Sub-module keypad_evt_fifo: a synchronous FIFO over key_evt_t with pointer-based full/empty, exposing push, pop, full, empty and the head entry.

## Test plan
Sim parameters for all scenarios: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=32, REPEAT_RATE=16, FIFO_DEPTH=4.

- **Clean press:** press row 2 / col 1 (code 9) for 20 cycles, then release. Required: exactly one event {0, 9}, tecla_valid at sample + 9, tecla_held high while held.
- **Bounce:** toggle the col line every 3 cycles for 30 cycles, then hold it low. Required: no event during bouncing, one event after 8 stable cycles.
- **Repeat:** hold code 5 for 100 cycles past the press event. Required: press event, then repeat events at +32, +48, +64, +80, +96 after the press. Release glitches shorter than 8 cycles produce no new press.
- **Overflow:** keep tecla_ready = 0 and generate 5 events. Required: the FIFO holds the first 4 events and overflow = 1. Popping with same-cycle push at full must lose no event.
- **Reset mid-debounce:** drive rst low during DEBOUNCE. Required: all outputs return to reset values on the next edge and no event is emitted.
- **Multi-key and wrap (ROWS=COLS=8):** press codes 63 and 0 simultaneously. Required: the row scan wraps 7 → 0, and the events follow scan order, with the lowest column winning on a shared row.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state and event types for the keypad matrix scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, REL_DEB} scan_state_t;

  localparam int DEFAULT_KEY_W = 4;

  // Default-width event for a 4x4 pad; the top builds its own for other sizes.
  typedef struct packed {
    logic                     is_repeat;
    logic [DEFAULT_KEY_W-1:0] code;
  } key_evt_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// rtl/keypad_evt_fifo.sv - synchronous key-event FIFO with wrap-bit full/empty
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter type entry_t = key_evt_t,
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  entry_t      mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + PTR_ONE;
      end
      if (do_pop) rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - row-strobed keypad scanner with debounce, typematic repeat and event FIFO
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS            = 4,
  parameter int  COLS            = 4,
  parameter int  SCAN_CYCLES     = 4,
  parameter int  DEBOUNCE_CYCLES = 100,
  parameter int  REPEAT_DELAY    = 0,
  parameter int  REPEAT_RATE     = 1,
  parameter int  FIFO_DEPTH      = 4,
  localparam int KEY_W           = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  col_matriz,
  output logic [ROWS-1:0]  lin_matriz,
  output logic [KEY_W-1:0] tecla_value,
  output logic             tecla_repeat,
  output logic             tecla_valid,
  input  logic             tecla_ready,
  output logic             tecla_held,
  output logic             overflow
);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int SCAN_W  = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = imax(REPEAT_DELAY, REPEAT_RATE);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [REP_W-1:0]  REP_SAT   = REP_W'(REP_MAX);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]  DELAY_V   = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0]  RATE_V    = REP_W'(REPEAT_RATE);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);

  typedef struct packed {
    logic             is_repeat;
    logic [KEY_W-1:0] code;
  } evt_t;

  scan_state_t       state;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  row_next;
  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  first_col;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_inc;
  logic              rep_phase;
  logic              rep_due;
  logic [COLS-1:0]   col_meta;
  logic [COLS-1:0]   col_s;
  logic              any_low;
  logic              key_up;
  logic              evt_push;
  logic              evt_rpt;
  logic              fifo_full;
  logic              fifo_empty;
  evt_t              evt_in;
  evt_t              evt_head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= col_matriz;
      col_s    <= col_meta;
    end
  end

  // Lowest-index low column wins when several keys share the strobed row.
  always_comb begin
    first_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_s[i]) first_col = COL_W'(i);
    end
  end

  assign any_low  = ~&col_s;
  assign key_up   = col_s[col_q];
  assign row_next = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
  assign rep_inc  = (rep_cnt == REP_SAT) ? rep_cnt : rep_cnt + REP_ONE;
  assign rep_due  = (REPEAT_DELAY != 0) &&
                    (rep_phase ? (rep_cnt >= RATE_V) : (rep_cnt >= DELAY_V));

  always_comb begin
    evt_push = 1'b0;
    evt_rpt  = 1'b0;
    case (state)
      DEBOUNCE: evt_push = !key_up && (deb_cnt == DEB_LAST);
      HELD: begin
        evt_push = !key_up && rep_due;
        evt_rpt  = 1'b1;
      end
      default: ;
    endcase
  end

  assign evt_in.is_repeat = evt_rpt;
  assign evt_in.code      = KEY_W'(row_q) * KEY_W'(COLS) + KEY_W'(col_q);

  // rep_cnt holds cycles since the last press or repeat push; it keeps running through REL_DEB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SCAN;
      row_q     <= '0;
      col_q     <= '0;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (any_low) begin
              col_q   <= first_col;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_q <= row_next;
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_ONE;
          end
        end
        DEBOUNCE: begin
          if (key_up) begin
            row_q <= row_next;
            state <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            rep_cnt   <= REP_ONE;
            rep_phase <= 1'b0;
            state     <= HELD;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end
        HELD: begin
          if (evt_push) begin
            rep_cnt   <= REP_ONE;
            rep_phase <= 1'b1;
          end else begin
            rep_cnt <= rep_inc;
          end
          if (key_up) begin
            deb_cnt <= '0;
            state   <= REL_DEB;
          end
        end
        default: begin
          rep_cnt <= rep_inc;
          if (!key_up) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            row_q <= row_next;
            state <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) overflow <= 1'b0;
    else if (evt_push && fifo_full && !(tecla_ready && !fifo_empty)) overflow <= 1'b1;
  end

  keypad_evt_fifo #(
    .entry_t (evt_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt_push),
    .push_data (evt_in),
    .pop       (tecla_ready),
    .head      (evt_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign lin_matriz   = ~(ROWS'(1) << row_q);
  assign tecla_value  = evt_head.code;
  assign tecla_repeat = evt_head.is_repeat;
  assign tecla_valid  = !fifo_empty;
  assign tecla_held   = (state == HELD) || (state == REL_DEB);

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_a, lin_a, val_a;
  logic        rpt_a, vld_a, rdy_a, held_a, ovf_a;
  logic [7:0]  col_b, lin_b;
  logic [5:0]  val_b;
  logic        rpt_b, vld_b, rdy_b, held_b, ovf_b;
  logic [15:0] keys_a;
  logic [63:0] keys_b;
  int          n_chk, n_fail;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(32), .REPEAT_RATE(16), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .col_matriz(col_a), .lin_matriz(lin_a),
    .tecla_value(val_a), .tecla_repeat(rpt_a), .tecla_valid(vld_a),
    .tecla_ready(rdy_a), .tecla_held(held_a), .overflow(ovf_a)
  );

  keypad_matrix_scanner #(
    .ROWS(8), .COLS(8), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(32), .REPEAT_RATE(16), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .col_matriz(col_b), .lin_matriz(lin_b),
    .tecla_value(val_b), .tecla_repeat(rpt_b), .tecla_valid(vld_b),
    .tecla_ready(rdy_b), .tecla_held(held_b), .overflow(ovf_b)
  );

  // Passive keypad: a pressed key shorts its column low while its row is strobed.
  always_comb begin
    col_a = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_a[r*4+c] && !lin_a[r]) col_a[c] = 1'b0;
  end

  always_comb begin
    col_b = '1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (keys_b[r*8+c] && !lin_b[r]) col_b[c] = 1'b0;
  end

  typedef struct {
    int row;
    int col;
    int code;
    int lat;
  } vec_t;

  vec_t vecs[5];
  int   exp_off[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return vld_a;
      1:       return !held_a;
      2:       return vld_b;
      default: return !held_b;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, output int n);
    n = 0;
    while (!cond(which) && n < limit) begin
      tick();
      n++;
    end
    if (!cond(which)) n = -1;
  endtask

  initial begin
    int n, ev;
    n_chk = 0; n_fail = 0;
    rst = 1'b0; keys_a = '0; keys_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;
    vecs[0] = '{2, 1,  9, 20};
    vecs[1] = '{0, 0,  0, 12};
    vecs[2] = '{3, 3, 15, 24};
    vecs[3] = '{1, 2,  6, 16};
    vecs[4] = '{2, 3, 11, 20};
    exp_off = '{32, 48, 64, 80, 96};

    do_reset();
    check("rst_lin", 32'(lin_a), 32'hE);
    check("rst_value", 32'(val_a), 0);
    check("rst_repeat", 32'(rpt_a), 0);
    check("rst_valid", 32'(vld_a), 0);
    check("rst_held", 32'(held_a), 0);
    check("rst_overflow", 32'(ovf_a), 0);
    check("rst_lin_8x8", 32'(lin_b), 32'hFE);

    rdy_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      keys_a = '0;
      keys_a[vecs[i].row*4 + vecs[i].col] = 1'b1;
      wait_for(0, 60, n);
      check($sformatf("press_latency_%0d", i), n, vecs[i].lat);
      check($sformatf("press_code_%0d", i), 32'(val_a), vecs[i].code);
      check($sformatf("press_repeat_%0d", i), 32'(rpt_a), 0);
      check($sformatf("press_held_%0d", i), 32'(held_a), 1);
      tick();
      check($sformatf("single_event_%0d", i), 32'(vld_a), 0);
      repeat (10) tick();
      check($sformatf("still_held_%0d", i), 32'(held_a), 1);
      keys_a = '0;
      ev = 0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (vld_a) ev++;
      end
      check($sformatf("release_no_event_%0d", i), ev, 0);
      check($sformatf("release_held_%0d", i), 32'(held_a), 0);
    end

    // Bounce on key 1 with a 3-cycle toggle, then a clean hold.
    do_reset();
    keys_a = '0;
    ev = 0;
    for (int k = 0; k < 30; k++) begin
      keys_a[1] = ((k / 3) % 2 == 0);
      tick();
      if (vld_a) ev++;
    end
    check("bounce_no_event", ev, 0);
    keys_a[1] = 1'b1;
    wait_for(0, 80, n);
    check("bounce_event_after_stable", 32'(n >= 10), 1);
    check("bounce_code", 32'(val_a), 1);
    check("bounce_repeat", 32'(rpt_a), 0);
    tick();
    check("bounce_single_event", 32'(vld_a), 0);
    keys_a = '0;
    repeat (30) tick();

    // Typematic repeat on key 5 with a 5-cycle release glitch.
    do_reset();
    keys_a = '0;
    keys_a[5] = 1'b1;
    wait_for(0, 60, n);
    check("rep_press_latency", n, 16);
    check("rep_press_code", 32'(val_a), 5);
    check("rep_press_flag", 32'(rpt_a), 0);
    ev = 0;
    for (int k = 1; k <= 100; k++) begin
      keys_a[5] = !(k >= 50 && k <= 54);
      tick();
      if (vld_a) begin
        if (ev < 5) check($sformatf("rep_offset_%0d", ev), k, exp_off[ev]);
        check("rep_flag", 32'(rpt_a), 1);
        check("rep_code", 32'(val_a), 5);
        ev++;
      end
    end
    check("rep_count", ev, 5);
    check("rep_held", 32'(held_a), 1);
    keys_a = '0;
    repeat (30) tick();

    // Overflow with consumer stalled, then a pop coinciding with a push at full.
    rdy_a = 1'b0;
    do_reset();
    keys_a = '0;
    keys_a[5] = 1'b1;
    wait_for(0, 60, n);
    check("ovf_press_latency", n, 16);
    repeat (79) tick();
    check("ovf_before_fifth", 32'(ovf_a), 0);
    check("ovf_head_is_press", 32'(rpt_a), 0);
    tick();
    check("ovf_set", 32'(ovf_a), 1);
    repeat (15) tick();
    check("ovf_head_before_swap", 32'(rpt_a), 0);
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
    check("ovf_swap_valid", 32'(vld_a), 1);
    check("ovf_swap_head", 32'(rpt_a), 1);
    keys_a = '0;
    rdy_a = 1'b1;
    ev = 0;
    for (int k = 0; k < 8; k++) begin
      if (vld_a) begin
        ev++;
        check("ovf_drain_flag", 32'(rpt_a), 1);
      end
      tick();
    end
    check("ovf_drain_count", ev, 4);
    check("ovf_sticky", 32'(ovf_a), 1);

    // Reset while a second key is debouncing and the FIFO holds an event.
    rdy_a = 1'b0;
    do_reset();
    keys_a = '0;
    keys_a[1] = 1'b1;
    wait_for(0, 60, n);
    check("mid_first_latency", n, 12);
    check("mid_first_code", 32'(val_a), 1);
    keys_a = '0;
    wait_for(1, 60, n);
    check("mid_release_seen", 32'(n >= 0), 1);
    check("mid_release_next_row", 32'(lin_a), 32'hD);
    keys_a[4] = 1'b1;
    repeat (6) tick();
    check("mid_deb_not_held", 32'(held_a), 0);
    check("mid_deb_fifo_loaded", 32'(vld_a), 1);
    rst = 1'b0;
    tick();
    check("mid_rst_lin", 32'(lin_a), 32'hE);
    check("mid_rst_value", 32'(val_a), 0);
    check("mid_rst_repeat", 32'(rpt_a), 0);
    check("mid_rst_valid", 32'(vld_a), 0);
    check("mid_rst_held", 32'(held_a), 0);
    check("mid_rst_overflow", 32'(ovf_a), 0);
    keys_a = '0;
    rst = 1'b1;
    ev = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (vld_a) ev++;
    end
    check("mid_rst_no_event", ev, 0);

    // 8x8: idle wrap, then scan-order events with lowest column winning.
    do_reset();
    rdy_b = 1'b1;
    keys_b = '0;
    repeat (28) tick();
    check("wrap_row7", 32'(lin_b), 32'h7F);
    repeat (4) tick();
    check("wrap_row0", 32'(lin_b), 32'hFE);
    keys_b[0] = 1'b1;
    keys_b[63] = 1'b1;
    keys_b[58] = 1'b1;
    wait_for(2, 60, n);
    check("mk_first_latency", n, 12);
    check("mk_first_code", 32'(val_b), 0);
    keys_b[0] = 1'b0;
    tick();
    wait_for(2, 200, n);
    check("mk_second_seen", 32'(n >= 0), 1);
    check("mk_lowest_col", 32'(val_b), 58);
    check("mk_second_repeat", 32'(rpt_b), 0);
    keys_b[58] = 1'b0;
    wait_for(3, 60, n);
    check("mk_release_seen", 32'(n >= 0), 1);
    check("mk_release_wraps", 32'(lin_b), 32'hFE);
    wait_for(2, 200, n);
    check("mk_third_seen", 32'(n >= 0), 1);
    check("mk_third_code", 32'(val_b), 63);
    keys_b = '0;
    repeat (20) tick();
    check("mk_no_overflow", 32'(ovf_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
